// File: rtl/picorv32_mem_pkg.sv
// Shared types and constants for the two-master picorv32 memory arbiter.
package picorv32_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/picorv32_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on contention the master that did not
// own the last transaction wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any_req
);

    always_comb begin
        any_req = |req;
        winner  = req[1];
        if (req == 2'b11) begin
            winner = ~last;
        end
    end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Shares one native picorv32 memory port between two masters, one registered
// transaction at a time, with a watchdog that aborts stalled slave accesses.
//   state | meaning
//   IDLE  | no transaction in flight; arbitrate pending requests
//   BUSY  | s_mem_valid high, waiting for slave ready or watchdog
//   RESP  | one-cycle ready pulse to the grantee (its valid is still high)
module picorv32_mem_arbiter
    import picorv32_mem_pkg::*;
#(
    parameter int          TIMEOUT  = 0,
    parameter logic [31:0] ERR_DATA = NOP_INSN,
    parameter int          CNT_W    = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,
    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,
    output logic        s_mem_valid,
    output logic        s_mem_instr,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,
    output logic        grant,
    output logic        timeout_err
);

    localparam bit               WD_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

    arb_state_t       state, state_next;
    mem_req_t         s_req, pick_req;
    logic [CNT_W-1:0] cnt;
    logic             winner, any_req, done, abort;
    logic [31:0]      rsp_data;

    rr_arb2 u_arb (
        .req     ({m1_mem_valid, m0_mem_valid}),
        .last    (grant),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        if (winner) begin
            pick_req.instr = m1_mem_instr;
            pick_req.addr  = m1_mem_addr;
            pick_req.wdata = m1_mem_wdata;
            pick_req.wstrb = m1_mem_wstrb;
        end else begin
            pick_req.instr = m0_mem_instr;
            pick_req.addr  = m0_mem_addr;
            pick_req.wdata = m0_mem_wdata;
            pick_req.wstrb = m0_mem_wstrb;
        end
    end

    // A real slave answer on the watchdog's last cycle takes precedence.
    assign done     = (state == ST_BUSY) && s_mem_ready;
    assign abort    = (state == ST_BUSY) && !s_mem_ready && WD_EN && (cnt == CNT_LAST);
    assign rsp_data = done ? s_mem_rdata : ERR_DATA;

    assign s_mem_instr = s_req.instr;
    assign s_mem_addr  = s_req.addr;
    assign s_mem_wdata = s_req.wdata;
    assign s_mem_wstrb = s_req.wstrb;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (any_req) state_next = ST_BUSY;
            ST_BUSY: if (done || abort) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_req        <= '0;
            s_mem_valid  <= 1'b0;
            m0_mem_ready <= 1'b0;
            m1_mem_ready <= 1'b0;
            m0_mem_rdata <= '0;
            m1_mem_rdata <= '0;
            timeout_err  <= 1'b0;
            cnt          <= '0;
            grant        <= 1'b1;
        end else begin
            m0_mem_ready <= 1'b0;
            m1_mem_ready <= 1'b0;
            timeout_err  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        s_req       <= pick_req;
                        s_mem_valid <= 1'b1;
                        grant       <= winner;
                        cnt         <= '0;
                    end
                end
                ST_BUSY: begin
                    if (done || abort) begin
                        s_mem_valid <= 1'b0;
                        timeout_err <= abort;
                        if (grant) begin
                            m1_mem_ready <= 1'b1;
                            m1_mem_rdata <= rsp_data;
                        end else begin
                            m0_mem_ready <= 1'b1;
                            m0_mem_rdata <= rsp_data;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_picorv32_mem_arbiter;
    import picorv32_mem_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_mem_valid = 1'b0, m0_mem_instr = 1'b0;
    logic [31:0] m0_mem_addr = '0, m0_mem_wdata = '0;
    logic [3:0]  m0_mem_wstrb = '0;
    logic        m1_mem_valid = 1'b0, m1_mem_instr = 1'b0;
    logic [31:0] m1_mem_addr = '0, m1_mem_wdata = '0;
    logic [3:0]  m1_mem_wstrb = '0;
    logic        m0_mem_ready, m1_mem_ready;
    logic [31:0] m0_mem_rdata, m1_mem_rdata;
    logic        s_mem_valid, s_mem_instr;
    logic [31:0] s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_wstrb;
    logic        s_mem_ready = 1'b0;
    logic [31:0] s_mem_rdata = '0;
    logic        grant, timeout_err;

    picorv32_mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(NOP_INSN), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn),
        .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr), .m0_mem_addr(m0_mem_addr),
        .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb),
        .m0_mem_ready(m0_mem_ready), .m0_mem_rdata(m0_mem_rdata),
        .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr), .m1_mem_addr(m1_mem_addr),
        .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb),
        .m1_mem_ready(m1_mem_ready), .m1_mem_rdata(m1_mem_rdata),
        .s_mem_valid(s_mem_valid), .s_mem_instr(s_mem_instr), .s_mem_addr(s_mem_addr),
        .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb),
        .s_mem_ready(s_mem_ready), .s_mem_rdata(s_mem_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h4) return 32'h0200_0113;
        return addr ^ 32'hA5A5_0000;
    endfunction

    function automatic mem_req_t mk(input logic instr, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] wstrb);
        mem_req_t r;
        r.instr = instr;
        r.addr  = addr;
        r.wdata = wdata;
        r.wstrb = wstrb;
        return r;
    endfunction

    // Slave: answers after slave_wait wait states, or never while slave_hang is set.
    int slave_wait = 0;
    bit slave_hang = 1'b0;
    int sw_cnt     = 0;
    always @(negedge clk) begin
        if (s_mem_valid) begin
            s_mem_rdata = mem_word(s_mem_addr);
            s_mem_ready = !slave_hang && (sw_cnt >= slave_wait);
            if (!s_mem_ready) sw_cnt++;
        end else begin
            s_mem_ready = 1'b0;
            sw_cnt      = 0;
        end
    end

    // Masters: hold valid until ready, then present the next queued request.
    mem_req_t q0[$], q1[$];
    mem_req_t r0, r1;
    always @(negedge clk) begin
        if (m0_mem_valid && m0_mem_ready) m0_mem_valid = 1'b0;
        if (!m0_mem_valid && q0.size() > 0) begin
            r0 = q0.pop_front();
            m0_mem_instr = r0.instr; m0_mem_addr = r0.addr;
            m0_mem_wdata = r0.wdata; m0_mem_wstrb = r0.wstrb;
            m0_mem_valid = 1'b1;
        end
        if (m1_mem_valid && m1_mem_ready) m1_mem_valid = 1'b0;
        if (!m1_mem_valid && q1.size() > 0) begin
            r1 = q1.pop_front();
            m1_mem_instr = r1.instr; m1_mem_addr = r1.addr;
            m1_mem_wdata = r1.wdata; m1_mem_wstrb = r1.wstrb;
            m1_mem_valid = 1'b1;
        end
    end

    // Reference model: who owns the slave, how long it has waited, who gets a reply.
    int          md_owner = -1;
    int          md_resp  = -1;
    int          md_last  = 1;
    int          md_wait  = 0;
    bit          md_err   = 1'b0;
    bit          had_resp;
    logic [31:0] md_rdata [2];
    mem_req_t    md_req;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            md_owner = -1; md_resp = -1; md_last = 1; md_wait = 0; md_err = 1'b0;
            md_rdata[0] = '0; md_rdata[1] = '0; md_req = '0;
        end else begin
            had_resp = (md_resp >= 0);
            md_resp  = -1;
            md_err   = 1'b0;
            if (md_owner >= 0) begin
                if (s_mem_ready) begin
                    md_resp = md_owner; md_rdata[md_owner] = s_mem_rdata; md_owner = -1;
                end else if (md_wait == TO - 1) begin
                    md_resp = md_owner; md_rdata[md_owner] = NOP_INSN; md_err = 1'b1; md_owner = -1;
                end else begin
                    md_wait++;
                end
            end else if (!had_resp && (m0_mem_valid || m1_mem_valid)) begin
                md_owner = (m0_mem_valid && m1_mem_valid) ? 1 - md_last : (m1_mem_valid ? 1 : 0);
                md_last  = md_owner;
                md_wait  = 0;
                md_req   = (md_owner == 1) ? mk(m1_mem_instr, m1_mem_addr, m1_mem_wdata, m1_mem_wstrb)
                                           : mk(m0_mem_instr, m0_mem_addr, m0_mem_wdata, m0_mem_wstrb);
            end
        end
    end

    int rdy_cnt0 = 0, rdy_cnt1 = 0, err_cnt = 0, run = 0, last_run = 0;
    int glog[$];

    always @(negedge clk) begin
        if (resetn) begin
            chk("s_valid", 32'(s_mem_valid), 32'(md_owner >= 0));
            if (md_owner >= 0) begin
                chk("s_addr",  s_mem_addr,         md_req.addr);
                chk("s_wdata", s_mem_wdata,        md_req.wdata);
                chk("s_wstrb", 32'(s_mem_wstrb),   32'(md_req.wstrb));
                chk("s_instr", 32'(s_mem_instr),   32'(md_req.instr));
            end
            chk("m0_ready", 32'(m0_mem_ready), 32'(md_resp == 0));
            chk("m1_ready", 32'(m1_mem_ready), 32'(md_resp == 1));
            chk("m0_rdata", m0_mem_rdata, md_rdata[0]);
            chk("m1_rdata", m1_mem_rdata, md_rdata[1]);
            chk("grant", 32'(grant), 32'(md_last));
            chk("timeout_err", 32'(timeout_err), 32'(md_err));
            if (m0_mem_ready) begin rdy_cnt0++; glog.push_back(0); end
            if (m1_mem_ready) begin rdy_cnt1++; glog.push_back(1); end
            if (timeout_err) err_cnt++;
            if (s_mem_valid) run++;
            else if (run > 0) begin last_run = run; run = 0; end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (n < budget && !(q0.size() == 0 && q1.size() == 0 && !m0_mem_valid && !m1_mem_valid
                               && !s_mem_valid && md_resp < 0)) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait_budget", 32'(n < budget), 32'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    int base0, base1, base_err;

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish at %0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd1);
        chk("rst_s_valid", 32'(s_mem_valid), 32'd0);
        chk("rst_s_addr", s_mem_addr, 32'd0);
        chk("rst_m0_ready", 32'(m0_mem_ready), 32'd0);
        chk("rst_m0_rdata", m0_mem_rdata, 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Contention, two wait states: grants alternate starting with master 0.
        slave_wait = 2;
        glog.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, 32'h200 + 32'(4 * i), 32'h0, 4'h0));
            q1.push_back(mk(1'b1, 32'h300 + 32'(4 * i), 32'h0, 4'h0));
        end
        wait_idle(300);
        chk("cont_count", 32'(glog.size()), 32'd8);
        foreach (glog[i]) chk("cont_order", 32'(glog[i]), 32'(i % 2));

        // Single read with zero-wait slave.
        slave_wait = 0;
        @(posedge clk); #1;
        q0.push_back(mk(1'b1, 32'h4, 32'h0, 4'h0));
        @(negedge clk); #1;
        chk("rd_req_up", 32'(m0_mem_valid), 32'd1);
        chk("rd_s_valid_early", 32'(s_mem_valid), 32'd0);
        @(negedge clk); #1;
        chk("rd_s_valid_lat1", 32'(s_mem_valid), 32'd1);
        chk("rd_s_addr", s_mem_addr, 32'h4);
        @(negedge clk); #1;
        chk("rd_m0_ready", 32'(m0_mem_ready), 32'd1);
        chk("rd_m0_rdata", m0_mem_rdata, 32'h0200_0113);
        chk("rd_grant", 32'(grant), 32'd0);
        chk("rd_m1_ready", 32'(m1_mem_ready), 32'd0);
        @(negedge clk); #1;
        chk("rd_ready_pulse_end", 32'(m0_mem_ready), 32'd0);
        wait_idle(50);

        // Write from master 1 with three wait states.
        slave_wait = 3;
        base1 = rdy_cnt1;
        @(posedge clk); #1;
        q1.push_back(mk(1'b0, 32'h100, 32'hDEAD_BEEF, 4'b0011));
        @(negedge clk); @(negedge clk); #1;
        chk("wr_s_valid", 32'(s_mem_valid), 32'd1);
        chk("wr_s_wstrb", 32'(s_mem_wstrb), 32'h3);
        chk("wr_s_wdata", s_mem_wdata, 32'hDEAD_BEEF);
        wait_idle(50);
        chk("wr_ready_pulses", 32'(rdy_cnt1 - base1), 32'd1);

        // Watchdog abort, then a normal request still completes.
        slave_hang = 1'b1;
        base_err = err_cnt;
        @(posedge clk); #1;
        q0.push_back(mk(1'b0, 32'h40, 32'h0, 4'h0));
        wait_idle(100);
        chk("to_valid_cycles", 32'(last_run), 32'd8);
        chk("to_err_pulses", 32'(err_cnt - base_err), 32'd1);
        chk("to_rdata", m0_mem_rdata, 32'h0000_0013);
        slave_hang = 1'b0;
        slave_wait = 1;
        @(posedge clk); #1;
        q0.push_back(mk(1'b0, 32'h44, 32'h0, 4'h0));
        wait_idle(50);
        chk("to_next_rdata", m0_mem_rdata, 32'hA5A5_0044);
        chk("to_next_no_err", 32'(err_cnt - base_err), 32'd1);

        // Slave answers on the watchdog's last cycle: real data, no error.
        slave_wait = 7;
        base_err = err_cnt;
        @(posedge clk); #1;
        q0.push_back(mk(1'b0, 32'h48, 32'h0, 4'h0));
        wait_idle(100);
        chk("bnd_valid_cycles", 32'(last_run), 32'd8);
        chk("bnd_no_err", 32'(err_cnt - base_err), 32'd0);
        chk("bnd_rdata", m0_mem_rdata, 32'hA5A5_0048);

        // Reset during a stalled access.
        slave_hang = 1'b1;
        @(posedge clk); #1;
        q0.push_back(mk(1'b0, 32'h50, 32'h0, 4'h0));
        repeat (5) @(negedge clk);
        #1;
        chk("rst2_busy_before", 32'(s_mem_valid), 32'd1);
        #1;
        resetn = 1'b0;
        q0.delete(); q1.delete();
        m0_mem_valid = 1'b0; m1_mem_valid = 1'b0;
        #1;
        chk("rst2_s_valid", 32'(s_mem_valid), 32'd0);
        chk("rst2_grant", 32'(grant), 32'd1);
        chk("rst2_m0_rdata", m0_mem_rdata, 32'd0);
        chk("rst2_m1_rdata", m1_mem_rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        slave_hang = 1'b0;
        slave_wait = 0;
        base0 = rdy_cnt0;
        repeat (4) @(negedge clk);
        #1;
        chk("rst2_no_stale_ready", 32'(rdy_cnt0 - base0), 32'd0);
        glog.delete();
        @(posedge clk); #1;
        q1.push_back(mk(1'b0, 32'h70, 32'h0, 4'h0));
        q0.push_back(mk(1'b0, 32'h60, 32'h0, 4'h0));
        wait_idle(60);
        chk("rst2_grant_count", 32'(glog.size()), 32'd2);
        if (glog.size() > 0) chk("rst2_first_winner", 32'(glog[0]), 32'd0);
        chk("rst2_m0_rdata_after", m0_mem_rdata, 32'hA5A5_0060);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/picorv32_mem_arbiter.md
Name: picorv32_mem_arbiter

Overview:
- Two-master round-robin arbiter sharing one native picorv32 memory port (valid/ready/addr/wdata/wstrb/instr/rdata) between two cores, or between a core and a DMA/debug master.
- Sits between the masters and the single memory/ROM model in the testbench or the SoC.
- Registers one transaction at a time to the slave and returns the response to the granted master.
- Includes a watchdog that aborts stalled slave accesses.

Parameters:
- TIMEOUT, 0, max cycles s_mem_valid may stay high without s_mem_ready before abort; 0 disables the watchdog.
- ERR_DATA, 32'h0000_0013, rdata returned on abort (ADDI x0,x0,0 = NOP).
- CNT_W, 16, watchdog counter width; TIMEOUT must be < 2**CNT_W.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- m0_mem_valid/m1_mem_valid  in  1  master request
- m0_mem_instr/m1_mem_instr  in  1  instruction fetch flag
- m0_mem_addr/m1_mem_addr  in  32  address
- m0_mem_wdata/m1_mem_wdata  in  32  write data
- m0_mem_wstrb/m1_mem_wstrb  in  4  byte strobes; 0 means read
- m0_mem_ready/m1_mem_ready  out  1  one-cycle completion pulse
- m0_mem_rdata/m1_mem_rdata  out  32  read data, valid while the matching ready is high
- s_mem_valid  out  1  slave request
- s_mem_instr  out  1
- s_mem_addr  out  32
- s_mem_wdata  out  32
- s_mem_wstrb  out  4
- s_mem_ready  in  1  slave completion
- s_mem_rdata  in  32
- grant  out  1  master owning the current or last transaction
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, resetn=0):
  - FSM=IDLE.
  - All s_* outputs, m*_mem_ready, m*_mem_rdata, timeout_err and watchdog counter = 0.
  - grant=1, so master 0 wins first.
  - Reset mid-transaction drops s_mem_valid immediately; no response is delivered.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - If only one mN_mem_valid is high, that master wins.
  - If both are high, the winner is the master that is not `grant` (round robin).
  - On the next edge: latch the winner's instr/addr/wdata/wstrb into the s_* registers, set s_mem_valid=1, set grant to the winner, go to BUSY.
  - Request-to-s_mem_valid latency is 1 cycle.
- BUSY:
  - s_* outputs are held stable.
  - The counter increments each cycle s_mem_valid is high.
  - If s_mem_ready=1 at an edge: s_mem_valid<=0; m{grant}_mem_ready<=1; m{grant}_mem_rdata<=s_mem_rdata; go to RESP.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1: s_mem_valid<=0; ready<=1; rdata<=ERR_DATA; timeout_err<=1; go to RESP.
  - If s_mem_ready and the timeout coincide, s_mem_ready wins and there is no error.
- RESP:
  - Lasts exactly one cycle; ready and timeout_err pulses are high here only.
  - Then clear ready/timeout_err, clear the counter, go to IDLE.
  - RESP exists because the master still drives valid while it samples ready. Re-arbitration therefore starts on the cycle after RESP, so the same request is never granted twice.
- Non-granted master:
  - Its ready stays 0 and its rdata holds its previous value.
  - Its request remains pending with no timeout.
- Fairness: with both masters continuously requesting, grants strictly alternate.
- Writes: s_mem_rdata is still captured into rdata; masters ignore it.
- Minimum transaction occupancy is 3 cycles (IDLE→BUSY→RESP) with a zero-wait slave.

Decomposition:
- Shared package `picorv32_mem_pkg`:
  - FSM state enum (IDLE/BUSY/RESP).
  - Request struct {instr, addr[31:0], wdata[31:0], wstrb[3:0]}.
  - Constant NOP_INSN = 32'h0000_0013, used as the ERR_DATA default.
- One sub-module is natural: `rr_arb2`, a combinational 2-way round-robin pick from (req[1:0], last grant) returning winner index and any_req.
- FSM, request registers and watchdog stay in the top.

Test Plan:
- Single master read: m0 reads addr 0x0000_0004; slave answers in the first BUSY cycle with 0x0200_0113.
  → s_mem_valid 1 cycle after request; m0_mem_ready pulses 1 cycle with rdata 0x0200_0113; grant=0; m1 ready stays 0.
- Contention: m0 and m1 both request continuously; slave has 2 wait states.
  → grants alternate 0,1,0,1 (first=0 after reset); each ready pulse goes only to the grantee; s_mem_addr matches that master.
- Write pass-through: m1 writes 0xDEAD_BEEF to 0x100 with wstrb 4'b0011.
  → s_mem_wstrb=4'b0011 and s_mem_wdata stable through all BUSY cycles; m1_mem_ready single pulse.
- Timeout: TIMEOUT=8, slave never readies.
  → s_mem_valid high exactly 8 cycles; then m0_mem_ready=1 with rdata=0x0000_0013 and timeout_err=1 for 1 cycle; next request still serviced.
- Timeout boundary: s_mem_ready on the same edge the counter hits TIMEOUT-1.
  → real rdata returned; timeout_err stays 0.
- Reset mid-BUSY: assert resetn low for 1 cycle during a stalled request.
  → all outputs 0 asynchronously; no stale ready pulse after release; grant=1; master 0 wins the next arbitration.
